// File: rtl/llr_load_ctrl.sv
// ---------------------------------------------------------------------------
// llr_load_ctrl
// Moves one codeword of received samples through the external combinational
// quantizer and writes the resulting LLRs into the decoder's channel-LLR
// memory at consecutive addresses, then hands the buffer over via done/ack.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a codeword (honoured in IDLE only)
//   snr_idx_cfg         : SNR LUT index, latched on accepted start
//   frac_w_cfg          : signed fractional width, latched on accepted start
//   s_valid/s_ready     : sample stream handshake
//   s_data              : signed Q5.11 received sample
//   q_snr_idx/q_frac_w  : latched quantizer configuration
//   q_data_in           : registered sample into the quantizer
//   q_llr               : quantizer result (combinational of q_* outputs)
//   mem_we/addr/wdata   : LLR memory write port
//   busy                : LOAD or DRAIN in progress
//   done                : buffer complete, waiting for dec_ack
//   dec_ack             : decoder took the buffer
//   sat_cnt             : count of saturated LLRs written this codeword
//
// Build option
//   LLR_SAT_STATS_EN    : when defined, sat_cnt counts writes of +max/-max
//                         LLRs; otherwise sat_cnt is tied to zero.
// ---------------------------------------------------------------------------
module llr_load_ctrl #(
  parameter int unsigned DATA_W   = 5,
  parameter int unsigned CODE_LEN = 648,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        snr_idx_cfg,
  input  logic [4:0]        frac_w_cfg,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_data,
  output logic [3:0]        q_snr_idx,
  output logic [4:0]        q_frac_w,
  output logic [15:0]       q_data_in,
  input  logic [DATA_W-1:0] q_llr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  input  logic              dec_ack,
  output logic [ADDR_W-1:0] sat_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CODE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_s_ready;
  logic               r_stg1_vld;
  logic               r_mem_we;
  logic               r_busy;
  logic               r_done;
  logic [ADDR_W-1:0]  r_acc_cnt;
  logic [ADDR_W-1:0]  r_wr_idx;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [15:0]        r_q_data_in;
  logic [3:0]         r_q_snr_idx;
  logic [4:0]         r_q_frac_w;

  logic               w_accept;
  logic               w_start_acc;

  assign w_accept    = s_valid & r_s_ready;
  assign w_start_acc = (r_state == ST_IDLE) & start;

  // Control FSM plus the two-stage sample -> quantizer -> memory pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s_ready   <= 1'b0;
      r_stg1_vld  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_acc_cnt   <= '0;
      r_wr_idx    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_q_data_in <= '0;
      r_q_snr_idx <= '0;
      r_q_frac_w  <= '0;
    end else begin
      // Stage 1: register the accepted sample into the quantizer
      r_stg1_vld <= w_accept;
      if (w_accept) begin
        r_q_data_in <= s_data;
      end

      // Stage 2: quantizer output settles during stage 1, write it out.
      // Write index holds at the last address rather than wrapping.
      r_mem_we <= r_stg1_vld;
      if (r_stg1_vld) begin
        r_mem_wdata <= q_llr;
        r_mem_addr  <= r_wr_idx;
        if (r_wr_idx != LAST_IDX) begin
          r_wr_idx <= r_wr_idx + ADDR_W'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_acc) begin
            r_q_snr_idx <= snr_idx_cfg;
            r_q_frac_w  <= frac_w_cfg;
            r_acc_cnt   <= '0;
            r_wr_idx    <= '0;
            r_s_ready   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (w_accept) begin
            if (r_acc_cnt == LAST_IDX) begin
              r_s_ready <= 1'b0;
              r_state   <= ST_DRAIN;
            end else begin
              r_acc_cnt <= r_acc_cnt + ADDR_W'(1);
            end
          end
        end

        // Only the final write of a codeword carries the last address
        ST_DRAIN: begin
          if (r_mem_we && (r_mem_addr == LAST_IDX)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        // start is ignored here, even when it coincides with dec_ack
        ST_DONE: begin
          if (dec_ack) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign q_data_in = r_q_data_in;
  assign q_snr_idx = r_q_snr_idx;
  assign q_frac_w  = r_q_frac_w;

`ifdef LLR_SAT_STATS_EN
  localparam logic [DATA_W-1:0] LLR_POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] LLR_NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};

  logic [ADDR_W-1:0] r_sat_cnt;
  logic              w_llr_sat;

  assign w_llr_sat = (q_llr == LLR_POS_MAX) | (q_llr == LLR_NEG_MAX);

  // Saturating count of full-scale LLRs, sampled as each write is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (w_start_acc) begin
      r_sat_cnt <= '0;
    end else if (r_stg1_vld && w_llr_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + ADDR_W'(1);
    end
  end

  assign sat_cnt = r_sat_cnt;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_llr_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_llr_load_ctrl
// Directed bench for llr_load_ctrl with CODE_LEN=8 and a pass-through
// quantizer stub (q_llr = q_data_in[4:0]).
// ---------------------------------------------------------------------------
module tb_llr_load_ctrl;

  localparam int unsigned DATA_W   = 5;
  localparam int unsigned CODE_LEN = 8;
  localparam int unsigned ADDR_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        snr_idx_cfg;
  logic [4:0]        frac_w_cfg;
  logic              s_valid;
  logic              s_ready;
  logic [15:0]       s_data;
  logic [3:0]        q_snr_idx;
  logic [4:0]        q_frac_w;
  logic [15:0]       q_data_in;
  logic [DATA_W-1:0] q_llr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              dec_ack;
  logic [ADDR_W-1:0] sat_cnt;

  always #5 clk = ~clk;

  // Quantizer stub
  assign q_llr = q_data_in[DATA_W-1:0];

  llr_load_ctrl #(
    .DATA_W   (DATA_W),
    .CODE_LEN (CODE_LEN),
    .ADDR_W   (ADDR_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .snr_idx_cfg (snr_idx_cfg),
    .frac_w_cfg  (frac_w_cfg),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .q_snr_idx   (q_snr_idx),
    .q_frac_w    (q_frac_w),
    .q_data_in   (q_data_in),
    .q_llr       (q_llr),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .dec_ack     (dec_ack),
    .sat_cnt     (sat_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  int done_cyc;

  int wa_q[$];
  int wd_q[$];
  int wc_q[$];
  int ac_q[$];

  logic [15:0] vec [CODE_LEN];

  always @(posedge clk) ncyc <= ncyc + 1;

  // Write and accept monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(int'(mem_wdata));
      wc_q.push_back(ncyc);
    end
    if (s_valid && s_ready) ac_q.push_back(ncyc);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Run one codeword from IDLE to DONE; toggle inserts a bubble every other cycle
  task automatic run_cw(input logic [3:0] snr, input logic [4:0] frac, input bit toggle);
    int  idx;
    int  it;
    int  g;
    logic acc;
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ac_q.delete();
    snr_idx_cfg = snr;
    frac_w_cfg  = frac;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    it  = 0;
    while (idx < int'(CODE_LEN) && it < 200) begin
      s_valid = toggle ? ((it % 2) == 0) : 1'b1;
      s_data  = vec[idx];
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      it++;
    end
    s_valid = 1'b0;
    chk("accepts_in_budget", 32'(idx), 32'(CODE_LEN));
    @(negedge clk);
    chk("ready_low_after_last", 32'(s_ready), 32'd0);
    g = 0;
    while (done !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 32'(done), 32'd1);
    done_cyc = ncyc;
  endtask

  task automatic check_writes(input int gap);
    logic [15:0] v;
    int d;
    chk("n_writes", 32'(wa_q.size()), 32'(CODE_LEN));
    chk("n_accepts", 32'(ac_q.size()), 32'(CODE_LEN));
    foreach (wa_q[i]) begin
      if (i < int'(CODE_LEN)) begin
        v = vec[i];
        chk($sformatf("addr%0d", i), 32'(wa_q[i]), 32'(i));
        chk($sformatf("wdata%0d", i), 32'(wd_q[i]), 32'(v[DATA_W-1:0]));
        if (i > 0) chk($sformatf("gap%0d", i), 32'(wc_q[i] - wc_q[i-1]), 32'(gap));
      end
    end
    if (wc_q.size() > 0 && ac_q.size() > 0) begin
      chk("accept_to_we", 32'(wc_q[0] - ac_q[0]), 32'd2);
      d = done_cyc - wc_q[wc_q.size()-1];
      chk("done_after_last_write", 32'(d >= 1 && d <= 2), 32'd1);
    end else begin
      chk("writes_present", 32'd0, 32'd1);
    end
  endtask

  task automatic ack_done();
    dec_ack = 1'b1;
    @(posedge clk); #1;
    dec_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g;
    logic acc;
    int exp_sat;

    rst = 1'b1; start = 1'b0; snr_idx_cfg = '0; frac_w_cfg = '0;
    s_valid = 1'b0; s_data = '0; dec_ack = 1'b0;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_q_snr", 32'(q_snr_idx), 32'd0);
    chk("rst_sat", 32'(sat_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back codeword
    for (int i = 0; i < int'(CODE_LEN); i++) vec[i] = 16'(i);
    run_cw(4'd3, 5'd2, 1'b0);
    check_writes(1);
    chk("t1_q_snr", 32'(q_snr_idx), 32'd3);
    chk("t1_q_frac", 32'(q_frac_w), 32'd2);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // DONE holds while start pulses without dec_ack
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      start       = (i % 2) == 0;
      snr_idx_cfg = 4'd7;
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_q_snr", 32'(q_snr_idx), 32'd3);
      @(posedge clk); #1;
    end
    start = 1'b1;
    ack_done();
    start = 1'b0;
    @(negedge clk);
    chk("ack_done_low", 32'(done), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_no_start_busy", 32'(busy), 32'd0);
    chk("ack_no_start_ready", 32'(s_ready), 32'd0);
    chk("ack_no_start_snr", 32'(q_snr_idx), 32'd3);
    @(posedge clk); #1;

    // Bubbles on s_valid
    for (int i = 0; i < int'(CODE_LEN); i++) vec[i] = 16'(10 + i);
    run_cw(4'd3, 5'd2, 1'b1);
    check_writes(2);
    ack_done();

    // Reset mid-codeword
    snr_idx_cfg = 4'd5; frac_w_cfg = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1;
    k = 0; g = 0;
    while (k < 4 && g < 20) begin
      s_data = 16'(k + 1);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) k++;
      g++;
    end
    chk("pre_rst_accepts", 32'(k), 32'd4);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_qdata", 32'(q_data_in), 32'd0);
    chk("mid_rst_snr", 32'(q_snr_idx), 32'd0);
    chk("mid_rst_frac", 32'(q_frac_w), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < int'(CODE_LEN); i++) vec[i] = 16'(20 + i);
    run_cw(4'd9, 5'd4, 1'b0);
    check_writes(1);
    chk("t4_q_snr", 32'(q_snr_idx), 32'd9);
    ack_done();

    // Saturation statistics
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      case (i % 3)
        0:       vec[i] = 16'h000F;
        1:       vec[i] = 16'h0010;
        default: vec[i] = 16'h0003;
      endcase
    end
`ifdef LLR_SAT_STATS_EN
    exp_sat = 6;
`else
    exp_sat = 0;
`endif
    run_cw(4'd1, 5'b11110, 1'b0);
    check_writes(1);
    chk("sat_cnt_done", 32'(sat_cnt), 32'(exp_sat));
    chk("t5_q_frac", 32'(q_frac_w), 32'd30);
    ack_done();
    @(negedge clk);
    chk("final_done_low", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/llr_load_ctrl.md
Name: llr_load_ctrl

Overview:
- Sequences one codeword of received channel samples through the external combinational quantizer.
- Writes the resulting DATA_W-bit LLRs into the decoder's channel-LLR memory at consecutive addresses.
- Latches the quantizer configuration (SNR index, fractional width) per codeword and hands the filled buffer to the LDPC decoder via a done/ack handshake.
- Sits between the sample source (valid/ready stream) and the decoder input memory.

Parameters:
- DATA_W, 5, LLR width; must match the quantizer's data_w.
- CODE_LEN, 648, number of samples (LLRs) per codeword.
- ADDR_W, 10, LLR memory address width; requires 2^ADDR_W >= CODE_LEN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse in IDLE: latch config and begin a codeword; ignored in other states
- snr_idx_cfg  input  4  SNR LUT index, sampled on accepted start
- frac_w_cfg  input  5  signed fractional width, sampled on accepted start
- s_valid  input  1  sample valid
- s_ready  output  1  sample accept
- s_data  input  16  signed Q5.11 received sample
- q_snr_idx  output  4  to quantizer snr_idx (latched config)
- q_frac_w  output  5  to quantizer frac_w (latched config)
- q_data_in  output  16  to quantizer data_in (registered sample)
- q_llr  input  DATA_W  from quantizer llr (combinational of q_* outputs)
- mem_we  output  1  LLR memory write enable
- mem_addr  output  ADDR_W  LLR memory write address
- mem_wdata  output  DATA_W  LLR memory write data
- busy  output  1  high in LOAD and DRAIN
- done  output  1  high in DONE: buffer complete
- dec_ack  input  1  decoder has taken the buffer; DONE -> IDLE
- sat_cnt  output  ADDR_W  saturated-LLR count (Optional Feature)

Behaviour:
- Reset: state IDLE; s_ready, mem_we, busy, done = 0; mem_addr, mem_wdata, q_data_in, q_snr_idx, q_frac_w, sample counter, sat_cnt = 0. Reset mid-codeword aborts it; partial memory contents are not cleared.
- IDLE: s_ready = 0. On start = 1, latch snr_idx_cfg/frac_w_cfg into q_snr_idx/q_frac_w, clear counter, go to LOAD.
- LOAD: s_ready = 1 while accepted-count < CODE_LEN. Accept = s_valid & s_ready.
  - On accept at edge t: q_data_in <= s_data; stage-1 valid set.
  - At edge t+1: mem_wdata <= q_llr; mem_addr <= write index; mem_we <= 1 for one cycle. Write index starts at 0 and increments per write.
  - Fixed latency is accept-edge to mem_we-high = 2 cycles. Full throughput is one sample per cycle; bubbles on s_valid pass through as mem_we = 0.
  - On the edge accepting sample CODE_LEN-1, s_ready drops next cycle and the state moves to DRAIN.
- DRAIN: s_ready = 0; wait until the last write (address CODE_LEN-1) has issued, then go to DONE.
- DONE: done = 1, busy = 0, s_ready = 0. Stays until dec_ack = 1, then goes to IDLE. start is ignored in DONE.
- q_snr_idx/q_frac_w hold constant from start until the next accepted start, so the config never changes mid-codeword.
- The write index never exceeds CODE_LEN-1; no wrap within a codeword; it is reset to 0 on each start.
- dec_ack outside DONE is ignored. start and dec_ack asserted together in DONE: take dec_ack only; start is not latched.

Optional Feature:
- Macro: LLR_SAT_STATS_EN.
- Defined: sat_cnt increments, saturating at all-ones, on each memory write whose q_llr equals +max (0 followed by ones) or -max (1 followed by zeros) in DATA_W bits. Cleared on start and on rst; stable and readable in DONE.
- Undefined: sat_cnt is tied to 0 and no counter logic is built.

Test Plan:
- CODE_LEN=8, bench quantizer stub q_llr = q_data_in[4:0], start with snr_idx=3, frac_w=2, s_valid held high, s_data=0..7 -> mem_we pulses 8 consecutive cycles, first 2 cycles after the first accept; addr 0..7, wdata 0..7; done high 1-2 cycles after last write; q_snr_idx=3, q_frac_w=2 throughout.
- Same setup, s_valid toggling 1,0,1,0 -> 8 writes with gaps, addresses still contiguous 0..7; exactly 8 accepts; s_ready = 0 after the 8th accept.
- In DONE, hold dec_ack=0 for 10 cycles while pulsing start -> done stays 1, no state change; then dec_ack=1 -> IDLE next cycle, done=0.
- rst asserted after 4 accepts -> next cycle all outputs 0, state IDLE; a new start with snr_idx=9 restarts from addr 0 with q_snr_idx=9.
- LLR_SAT_STATS_EN defined, stub outputs 5'b01111, 5'b10000, 5'b00011 repeating over 8 samples -> sat_cnt=6 at DONE; macro undefined -> sat_cnt=0.
